// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: types and limits shared by the sequential arithmetic cells.
// Contents: sub_state_e (FSM states of serial_subtractor), SUB_WIDTH_MAX.
// Latency/backpressure: not applicable (declarations only).
package serial_arith_pkg;

  // Control states of the bit-serial subtractor.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

  // Widest operand the serial datapath is built for.
  localparam int SUB_WIDTH_MAX = 64;

endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: one-bit full subtractor, d = x - y - bin with borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs.
// Ports: x (minuend bit), y (subtrahend bit), bin (borrow in),
//        d (difference bit), bout (borrow out).
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when y exceeds x, or when x == y and a borrow is already pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial diff = a - b, LSB first, through one full_sub_cell.
// Latency: done pulses WIDTH+1 clocks after an accepted start; one op per WIDTH+2 clocks.
// Backpressure: start is sampled only while ready=1; requests in SHIFT/DONE are dropped.
// Ports: clk, rst_n (async, active low), start, a, b -> ready, busy, done,
//        diff, borrow, and ovf (signed overflow, only with SERIAL_SUB_OVF_EN defined).
// Config macro: SERIAL_SUB_OVF_EN adds the ovf port and its sign-capture flops.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > SUB_WIDTH_MAX) begin : g_bad_width
    $error("serial_subtractor: WIDTH out of range");
  end

  sub_state_e       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic             bflop;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bout;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits kept aside, since a_sr/b_sr are shifted away.
  logic a_msb;
  logic b_msb;
`endif

  full_sub_cell u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (bflop),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Result register after this bit: shift right, new bit enters at the MSB.
  // Written bitwise so WIDTH=1 needs no empty slice.
  always_comb begin
    r_nxt            = r_sr >> 1;
    r_nxt[WIDTH-1]   = cell_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      bflop  <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            r_sr  <= '0;
            bflop <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
            state <= SHIFT;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end

        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= r_nxt;
          bflop <= cell_bout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Last bit: publish the result so it is valid alongside done.
            diff   <= r_nxt;
            borrow <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
            // The final d is the result sign bit.
            ovf    <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors for serial_subtractor at WIDTH=8.
// Expected results are hand-computed constants; ovf is checked only when
// SERIAL_SUB_OVF_EN is defined for the build.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge with start already driven high. Counts rising edges,
  // the start-sampling edge being number 1, until done is seen; start drops
  // after the first edge. Returns 0 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      if (i == 1) begin
        #1 start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    wait_done(n);
    check({tag, "_latency"}, n, 9);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_borrow"}, borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo) begin end
`endif
  endtask

  initial begin
    int n;
    int done_cnt;
    logic ready_low;
    logic diff_stable;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    // Busy/ready right after acceptance.
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("acc_busy", busy, 1);
    check("acc_ready", ready, 0);
    repeat (10) @(negedge clk);
    check("op0503_diff", diff, 8'h02);

    run_op("op0503", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("op0305", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("op0000", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("op8001", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

    // Extra starts during SHIFT and DONE must be ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    n = 0;
    done_cnt = 0;
    ready_low = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start = 1'b0;
      if (i == 3) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
      if (!done && ready) ready_low = 1'b0;
      if (done) begin n = i; break; end
    end
    check("ign_latency", n, 9);
    check("ign_ready_low", ready_low, 1);
    check("ign_diff", diff, 8'h0F);
    start = 1'b1;               // pulse during DONE
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("ign_ready_e9", ready, 1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("ign_no_second_done", done_cnt, 0);
    check("ign_diff_hold", diff, 8'h0F);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_diff", diff, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);
    run_op("op2021", 8'h20, 8'h21, 8'hFF, 1'b1, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'h0A; b = 8'h03; start = 1'b1;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
    end
    check("b2b_first_latency", n, 9);
    check("b2b_first_diff", diff, 8'h07);
    a = 8'h01; b = 8'h02;
    @(negedge clk);
    check("b2b_ready_gap", ready, 1);
    @(negedge clk);
    check("b2b_reaccept_busy", busy, 1);
    n = 0;
    diff_stable = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
      if (diff !== 8'h07) diff_stable = 1'b0;
    end
    start = 1'b0;
    check("b2b_diff_held", diff_stable, 1);
    check("b2b_second_latency", n, 8);
    check("b2b_second_diff", diff, 8'hFF);
    check("b2b_second_borrow", borrow, 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
